sr_latch_bank_ctrl: RTL and testbench

- Controller that shares a bank of NLATCH enabled SR latches among NREQ requesters.
- Each requester asks to set or clear one latch by index.
- The block round-robin arbitrates, then drives S/R/En to the selected latch with a safe setup, pulse and hold sequence.
- It reads back Q to confirm the write, reporting done or err.
- Sits between control logic and the latch bank, so nothing else drives latch S/R/En directly.

---
 rtl/sr_latch_bank_ctrl_if.sv | 29 ++
 rtl/sr_latch_bank_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sr_latch_bank_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_bank_ctrl_if.sv
// Requester and latch-bank signal bundle for sr_latch_bank_ctrl.
// The master side drives the requests and the latch read-back Q; the slave is the controller.
interface sr_latch_bank_ctrl_if #(
    parameter int NREQ   = 4,
    parameter int NLATCH = 8,
    parameter int IDXW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] sel;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [NLATCH-1:0]    S;
    logic [NLATCH-1:0]    R;
    logic [NLATCH-1:0]    En;
    logic [NLATCH-1:0]    Q;

    modport master (
        output req, op, sel, Q,
        input  gnt, busy, done, err, S, R, En
    );

    modport slave (
        input  req, op, sel, Q,
        output gnt, busy, done, err, S, R, En
    );
endinterface

// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin arbiter and setup/pulse/hold sequencer for a bank of enabled SR latches.
// All outputs are registered from next-state values, so each output matches its state exactly.
module sr_latch_bank_ctrl #(
    parameter int NREQ         = 4,
    parameter int NLATCH       = 8,
    parameter int IDXW         = 3,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sr_latch_bank_ctrl_if.slave  bus
);
    localparam int              PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]   LAST_REQ   = PW'(NREQ - 1);
    localparam logic [3:0]      PULSE_LAST = 4'(PULSE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              op_r, op_s;
    logic [IDXW-1:0]   sel_r, sel_s;
    logic [NREQ-1:0]   win_r, win_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [NLATCH-1:0] set_r, set_s;
    logic [NLATCH-1:0] clr_r, clr_s;
    logic [NLATCH-1:0] en_r, en_s;
    logic [NLATCH-1:0] line_s;
    logic              drive_s;
    logic              found_s;
    logic [PW-1:0]     arb_idx_s;
    logic              arb_op_s;
    logic [IDXW-1:0]   arb_sel_s;

    // Index to one-hot latch line; an index outside the bank yields all zeros.
    function automatic logic [NLATCH-1:0] idx_decode(input logic [IDXW-1:0] idx);
        logic [NLATCH-1:0] line;
        line = '0;
        for (int i = 0; i < NLATCH; i++) begin
            line[i] = (idx == IDXW'(i));
        end
        return line;
    endfunction

    function automatic logic q_pick(input logic [NLATCH-1:0] q, input logic [IDXW-1:0] idx);
        return |(q & idx_decode(idx));
    endfunction

    // Round-robin scan: first requesting index at or after the pointer, wrapping.
    always_comb begin
        int  idx_v;
        logic hit_v;
        idx_v     = 0;
        hit_v     = 1'b0;
        found_s   = 1'b0;
        arb_idx_s = '0;
        arb_op_s  = 1'b0;
        arb_sel_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v     = (int'(ptr_r) + k) % NREQ;
            hit_v     = bus.req[idx_v] && !found_s;
            arb_idx_s = hit_v ? PW'(idx_v) : arb_idx_s;
            arb_op_s  = hit_v ? bus.op[idx_v] : arb_op_s;
            arb_sel_s = hit_v ? bus.sel[idx_v*IDXW +: IDXW] : arb_sel_s;
            found_s   = found_s | hit_v;
        end
    end

    // Next-state, pointer and captured-request logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        op_s    = op_r;
        sel_s   = sel_r;
        win_s   = win_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    op_s    = arb_op_s;
                    sel_s   = arb_sel_s;
                    win_s   = NREQ'(1) << arb_idx_s;
                    ptr_s   = (arb_idx_s == LAST_REQ) ? PW'(0) : arb_idx_s + PW'(1);
                    cnt_s   = 4'd0;
                    state_s = (|idx_decode(arb_sel_s)) ? ST_SETUP : ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_PULSE;
                cnt_s   = 4'd1;
            end
            ST_PULSE: begin
                if (cnt_r >= PULSE_LAST) begin
                    state_s = ST_HOLD;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_HOLD:  state_s = ST_CHECK;
            ST_CHECK: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; Q is judged at the end of HOLD.
    always_comb begin
        line_s  = idx_decode(sel_s);
        drive_s = (state_s == ST_SETUP) || (state_s == ST_PULSE) || (state_s == ST_HOLD);
        gnt_s   = ((state_s == ST_SETUP) || ((state_s == ST_CHECK) && (state_r == ST_IDLE)))
                  ? win_s : '0;
        set_s   = (drive_s && op_s)  ? line_s : '0;
        clr_s   = (drive_s && !op_s) ? line_s : '0;
        en_s    = (state_s == ST_PULSE) ? line_s : '0;
        busy_s  = (state_s != ST_IDLE);
        done_s  = (state_s == ST_CHECK);
        err_s   = done_s && (!(|line_s) || (q_pick(bus.Q, sel_s) != op_s));
    end

    // State and output registers; reset releases every latch drive on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            cnt_r   <= 4'd0;
            op_r    <= 1'b0;
            sel_r   <= '0;
            win_r   <= '0;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            set_r   <= '0;
            clr_r   <= '0;
            en_r    <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            sel_r   <= sel_s;
            win_r   <= win_s;
            gnt_r   <= gnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            set_r   <= set_s;
            clr_r   <= clr_s;
            en_r    <= en_s;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign bus.S    = set_r;
    assign bus.R    = clr_r;
    assign bus.En   = en_r;
endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed and randomized bench for sr_latch_bank_ctrl with a transaction-level model
// of the arbitration order, the per-cycle latch drive profile and a latch bank that follows En.
module tb_sr_latch_bank_ctrl;
    localparam int NREQ   = 4;
    localparam int NLATCH = 6;
    localparam int IDXW   = 3;
    localparam int P      = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sr_latch_bank_ctrl_if #(.NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW)) bus ();

    sr_latch_bank_ctrl #(.NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW), .PULSE_CYCLES(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NLATCH-1:0] bank = '0;
    logic [NLATCH-1:0] force_mask;
    logic [NLATCH-1:0] force_val;
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ptr_m;

    // Latch bank model: an enabled latch takes S (set) or R (clear).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NLATCH; i++) begin
            if (bus.En[i] && bus.S[i]) bank[i] <= 1'b1;
            else if (bus.En[i] && bus.R[i]) bank[i] <= 1'b0;
        end
    end
    assign bus.Q = (bank & ~force_mask) | (force_val & force_mask);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [NREQ-1:0] g, input logic b,
                           input logic d, input logic e, input logic [NLATCH-1:0] s,
                           input logic [NLATCH-1:0] r, input logic [NLATCH-1:0] en);
        chk({tag, ".gnt"},  32'(bus.gnt),  32'(g));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".err"},  32'(bus.err),  32'(e));
        chk({tag, ".S"},    32'(bus.S),    32'(s));
        chk({tag, ".R"},    32'(bus.R),    32'(r));
        chk({tag, ".En"},   32'(bus.En),   32'(en));
    endtask

    // Called at a negedge in an IDLE cycle with requests already applied.
    task automatic txn(input bit keep, output int gcyc, output int w);
        bit found;
        bit o_v;
        bit err_e;
        logic [IDXW-1:0]   s_v;
        logic [NLATCH-1:0] line;
        logic [NREQ-1:0]   gmask;
        found = 1'b0;
        w     = -1;
        gcyc  = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(ptr_m + k) % NREQ]) begin
                found = 1'b1;
                w     = (ptr_m + k) % NREQ;
            end
        end
        if (!found) begin
            @(negedge clk);
            chk_out("noreq", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        o_v   = bus.op[w];
        s_v   = bus.sel[w*IDXW +: IDXW];
        line  = '0;
        if (int'(s_v) < NLATCH) line[s_v] = 1'b1;
        gmask = '0;
        gmask[w] = 1'b1;
        ptr_m = (w + 1) % NREQ;
        @(negedge clk);
        gcyc = cyc;
        if (!keep) bus.req[w] = 1'b0;
        if (line == '0) begin
            chk_out("oor", gmask, 1'b1, 1'b1, 1'b1, '0, '0, '0);
            @(negedge clk);
            chk_out("oor_idle", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            return;
        end
        err_e = ((force_mask[s_v] ? force_val[s_v] : o_v) != o_v);
        chk_out("setup", gmask, 1'b1, 1'b0, 1'b0, o_v ? line : '0, o_v ? '0 : line, '0);
        for (int c = 1; c <= P; c++) begin
            @(negedge clk);
            chk_out("pulse", '0, 1'b1, 1'b0, 1'b0, o_v ? line : '0, o_v ? '0 : line, line);
        end
        @(negedge clk);
        chk_out("hold", '0, 1'b1, 1'b0, 1'b0, o_v ? line : '0, o_v ? '0 : line, '0);
        @(negedge clk);
        chk_out("check", '0, 1'b1, 1'b1, err_e, '0, '0, '0);
        @(negedge clk);
        chk_out("idle", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        if (!err_e) chk("qback", 32'(bus.Q[s_v]), 32'(o_v));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int w;
        int prev;
        logic [NLATCH-1:0] one_hot;
        reset      = 1'b1;
        bus.req    = '0;
        bus.op     = '0;
        bus.sel    = '0;
        force_mask = '0;
        force_val  = '0;
        ptr_m      = 0;
        repeat (2) @(negedge clk);
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        @(negedge clk);
        chk_out("post_reset", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // single set of latch 2 from requester 0
        bus.op[0] = 1'b1; bus.sel[0 +: IDXW] = 3'd2; bus.req[0] = 1'b1;
        txn(1'b0, g, w);
        chk("single_who", 32'(w), 32'd0);
        chk("single_q2", 32'(bus.Q[2]), 32'd1);

        // round robin with all requests held continuously
        reset = 1'b1; @(negedge clk); reset = 1'b0; ptr_m = 0;
        bus.op  = 4'b0101;
        bus.sel = {3'd3, 3'd0, 3'd1, 3'd4};
        bus.req = 4'b1111;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            txn(1'b1, g, w);
            chk("rr_order", 32'(w), 32'(n % NREQ));
            if (n > 0) chk("rr_space", 32'(g - prev), 32'(P + 4));
            prev = g;
        end
        bus.req = '0;

        // set then clear latch 5
        bus.op[0] = 1'b1; bus.sel[0 +: IDXW] = 3'd5; bus.req[0] = 1'b1;
        txn(1'b0, g, w);
        bus.op[2] = 1'b0; bus.sel[2*IDXW +: IDXW] = 3'd5; bus.req[2] = 1'b1;
        txn(1'b0, g, w);
        chk("clear_who", 32'(w), 32'd2);
        chk("clear_q5", 32'(bus.Q[5]), 32'd0);

        // read-back mismatch on latch 1
        force_mask = 6'b000010; force_val = 6'b000000;
        bus.op[3] = 1'b1; bus.sel[3*IDXW +: IDXW] = 3'd1; bus.req[3] = 1'b1;
        txn(1'b0, g, w);
        force_mask = '0;

        // reset during the first PULSE cycle of a set from requester 1
        bus.op[1] = 1'b1; bus.sel[1*IDXW +: IDXW] = 3'd4; bus.req[1] = 1'b1;
        @(negedge clk);
        chk("abort_gnt", 32'(bus.gnt), 32'b0010);
        bus.req[1] = 1'b0;
        @(negedge clk);
        one_hot = 6'b010000;
        chk("abort_pulse_en", 32'(bus.En), 32'(one_hot));
        reset = 1'b1;
        @(negedge clk);
        chk_out("abort_reset", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        ptr_m = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_out("abort_quiet", '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        bus.op[3] = 1'b0; bus.sel[3*IDXW +: IDXW] = 3'd0;
        bus.op[1] = 1'b0; bus.sel[1*IDXW +: IDXW] = 3'd4;
        bus.req = 4'b1010;
        txn(1'b0, g, w);
        chk("abort_ptr0", 32'(w), 32'd1);
        txn(1'b0, g, w);
        chk("abort_next", 32'(w), 32'd3);

        // out-of-range index then a normal request
        bus.op[0] = 1'b1; bus.sel[0 +: IDXW] = 3'd7;
        bus.op[1] = 1'b1; bus.sel[1*IDXW +: IDXW] = 3'd3;
        bus.req = 4'b0011;
        txn(1'b0, g, w);
        chk("oor_who", 32'(w), 32'd0);
        txn(1'b0, g, w);
        chk("oor_next_who", 32'(w), 32'd1);
        chk("oor_next_q3", 32'(bus.Q[3]), 32'd1);

        // randomized traffic; pending requests keep their op/sel until granted
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && ($urandom_range(0, 1) == 1)) begin
                    bus.req[i] = 1'b1;
                    bus.op[i]  = 1'($urandom_range(0, 1));
                    bus.sel[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
                end
            end
            txn(1'b0, g, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
